// File: rtl/vga_pixel_timing_gen.sv
// VGA raster generator and frame-FIFO reader with position, sync and blank aligned to each pixel.
// Optional build macro: VGA_TIMING_TEST_PATTERN_EN adds an internal colour-bar source.
module vga_pixel_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iEN,
   input  logic        iFIFO_EMPTY,
   input  logic [9:0]  iRED,
   input  logic [9:0]  iGREEN,
   input  logic [9:0]  iBLUE,
   input  logic        iPATTERN_SEL,
   output logic        oREQUEST,
   output logic [12:0] oX_POS,
   output logic [12:0] oY_POS,
   output logic [9:0]  oRED,
   output logic [9:0]  oGREEN,
   output logic [9:0]  oBLUE,
   output logic        oH_SYNC,
   output logic        oV_SYNC,
   output logic        oBLANK_N,
   output logic        oFRAME_START,
   output logic        oUNDERFLOW
);

   localparam logic [12:0] H_LAST   = 13'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [12:0] V_LAST   = 13'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
   localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
   localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FRONT);
   localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FRONT);
   localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FRONT + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic [12:0] h_cnt_q, v_cnt_q;

   logic run_d, active_d, hs_n_d, vs_n_d, fs_d, uf_d, frame_wrap_d, pat_mode;

   logic [12:0] x1_q, y1_q;
   logic        hs1_q, vs1_q, blank1_q, fs1_q, grant1_q, uf1_q;
   logic [9:0]  red_d, green_d, blue_d;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (iEN) state_q <= RUN;
            RUN: begin
               if (h_cnt_q == H_LAST) begin
                  h_cnt_q <= '0;
                  if (v_cnt_q == V_LAST) begin
                     v_cnt_q <= '0;
                     // iEN only matters here, so a running frame always completes
                     if (!iEN) state_q <= IDLE;
                  end else begin
                     v_cnt_q <= v_cnt_q + 13'd1;
                  end
               end else begin
                  h_cnt_q <= h_cnt_q + 13'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign run_d        = (state_q == RUN);
   assign active_d     = run_d && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_n_d       = !(run_d && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
   assign vs_n_d       = !(run_d && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
   assign fs_d         = run_d && (h_cnt_q == '0) && (v_cnt_q == '0);
   assign frame_wrap_d = ((state_q == IDLE) && iEN) ||
                         (run_d && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST));
   assign oREQUEST     = active_d && !iFIFO_EMPTY && !pat_mode;
   assign uf_d         = active_d && iFIFO_EMPTY && !pat_mode;

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam logic [12:0] BAR_W = 13'(H_ACTIVE / 8);

   logic       pat_q, pat1_q;
   logic [2:0] bar1_q;

   // Mode is latched for a whole frame so a frame never mixes sources
   always_ff @(posedge iCLK) begin
      if (!iRST_N)           pat_q <= 1'b0;
      else if (frame_wrap_d) pat_q <= iPATTERN_SEL;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         pat1_q <= 1'b0;
         bar1_q <= '0;
      end else begin
         pat1_q <= pat_q;
         bar1_q <= 3'(h_cnt_q / BAR_W);
      end
   end

   assign pat_mode = pat_q;
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = iPATTERN_SEL ^ frame_wrap_d;
   assign pat_mode = 1'b0;
`endif

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         x1_q     <= '0;
         y1_q     <= '0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         blank1_q <= 1'b0;
         fs1_q    <= 1'b0;
         grant1_q <= 1'b0;
         uf1_q    <= 1'b0;
      end else begin
         x1_q     <= h_cnt_q;
         y1_q     <= v_cnt_q;
         hs1_q    <= hs_n_d;
         vs1_q    <= vs_n_d;
         blank1_q <= active_d;
         fs1_q    <= fs_d;
         grant1_q <= oREQUEST;
         uf1_q    <= uf_d;
      end
   end

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (grant1_q) begin
         red_d   = iRED;
         green_d = iGREEN;
         blue_d  = iBLUE;
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0]
      if (blank1_q && pat1_q) begin
         red_d   = {10{~bar1_q[1]}};
         green_d = {10{~bar1_q[2]}};
         blue_d  = {10{~bar1_q[0]}};
      end
`endif
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         oX_POS       <= '0;
         oY_POS       <= '0;
         oRED         <= '0;
         oGREEN       <= '0;
         oBLUE        <= '0;
         oH_SYNC      <= 1'b1;
         oV_SYNC      <= 1'b1;
         oBLANK_N     <= 1'b0;
         oFRAME_START <= 1'b0;
         oUNDERFLOW   <= 1'b0;
      end else begin
         oX_POS       <= x1_q;
         oY_POS       <= y1_q;
         oRED         <= red_d;
         oGREEN       <= green_d;
         oBLUE        <= blue_d;
         oH_SYNC      <= hs1_q;
         oV_SYNC      <= vs1_q;
         oBLANK_N     <= blank1_q;
         oFRAME_START <= fs1_q;
         oUNDERFLOW   <= oUNDERFLOW | uf1_q;
      end
   end

endmodule

// File: doc/vga_pixel_timing_gen.md
# vga_pixel_timing_gen

Producer side of the pixel path that feeds `vga_user_decorator`. It generates the VGA raster (horizontal/vertical counters, sync, blanking) and issues read requests to the frame FIFO. It presents each FIFO pixel together with its X/Y position, sync and blank, all aligned on the same cycle. Outputs drive the decorator's `iX_POS`/`iY_POS`/`iRED..iBLUE` inputs and the VGA DAC sync/blank pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- iCLK  in  1  pixel clock; all logic on its rising edge
- iRST_N  in  1  synchronous, active-low reset
- iEN  in  1  run enable, sampled only at frame boundaries
- iFIFO_EMPTY  in  1  frame FIFO empty flag
- iRED / iGREEN / iBLUE  in  10 each  FIFO read data, valid the cycle after oREQUEST
- iPATTERN_SEL  in  1  test-pattern select (see Configuration)
- oREQUEST  out  1  FIFO read request, one word per asserted cycle
- oX_POS / oY_POS  out  13 each  raster position of the pixel on oRED..oBLUE
- oRED / oGREEN / oBLUE  out  10 each  pixel colour, 0 outside active area
- oH_SYNC / oV_SYNC  out  1  sync, active low
- oBLANK_N  out  1  high during active area
- oFRAME_START  out  1  one-cycle pulse with pixel (0,0)
- oUNDERFLOW  out  1  sticky FIFO-underflow flag

## Operation
- H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525).
- Counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1). Order within each: active, front porch, sync, back porch.
- h_cnt wraps to 0 after H_TOTAL-1 and increments v_cnt. v_cnt wraps to 0 after V_TOTAL-1 on the last h_cnt.
- FSM:
  - IDLE: counters held at 0; all outputs at reset values. Move to RUN when iEN=1.
  - RUN: counters advance every cycle. At h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, go to IDLE if iEN=0, else stay in RUN.
  - iEN is ignored elsewhere, so a frame is never truncated.
- Active area (stage 0): RUN, h_cnt<H_ACTIVE, v_cnt<V_ACTIVE.
- oREQUEST = active & !iFIFO_EMPTY. It is combinational from registered state and the empty flag only.
- Underflow: active & iFIFO_EMPTY sets oUNDERFLOW. The flag clears only on reset. The colour output for that pixel is 0.
- Sync (stage 0):
  - hsync low when H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync low when V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - In IDLE, both syncs are high.
- oX_POS/oY_POS report the raw counter values, including during blanking.

## Timing
- Pipeline:
  - Stage 0: counters, request.
  - Stage 1: registers position, syncs, blank and the "granted" bit. FIFO data is valid during stage 1.
  - Stage 2: output registers, colours blanked/gated.
- Latency: 2 cycles from counter value to all outputs. Every output of a given pixel appears on the same cycle.
- oFRAME_START is high exactly when oX_POS=0, oY_POS=0 and the pixel is from a RUN frame.
- Reset values: oREQUEST=0, oX_POS=0, oY_POS=0, colours=0, oH_SYNC=1, oV_SYNC=1, oBLANK_N=0, oFRAME_START=0, oUNDERFLOW=0, FSM=IDLE.
- Reset asserted mid-frame: on the next edge all pipeline stages clear to these values, and the FSM goes to IDLE. A partially read line is not recovered; the FIFO owner flushes it.
- iEN and iFIFO_EMPTY changing in the same cycle are independent. The FIFO-empty gating applies regardless of iEN.

## Configuration
- `VGA_TIMING_TEST_PATTERN_EN` defined:
  - When iPATTERN_SEL=1, oREQUEST is held 0, underflow detection is disabled, and active pixels come from an internal pattern.
  - The pattern is 8 vertical bars, each H_ACTIVE/8 (80) wide, left to right: white, yellow, cyan, green, magenta, red, blue, black. Component values are 10'h3FF or 0.
  - Latency and sync timing are identical in both modes. iPATTERN_SEL takes effect only at frame start.
- Not defined: iPATTERN_SEL is ignored and no pattern logic is synthesised.

## Test plan
- Basic raster: release reset with iEN=1 and iFIFO_EMPTY=0.
  - oREQUEST is high 640 cycles, then low 160, repeating for 480 lines, then low for 45 lines.
  - oFRAME_START pulses once every 420000 cycles.
- Horizontal sync: oH_SYNC is low for exactly 96 cycles. The first low cycle coincides with oX_POS=656, and oBLANK_N=0 throughout.
- Vertical sync: oV_SYNC is low for exactly 1600 cycles, starting with oY_POS=490, oX_POS=0.
- Data alignment and underflow:
  - FIFO model returns data = x on all three components; the output shows oRED=oX_POS at every active pixel.
  - Pull iFIFO_EMPTY high for one cycle at x=100, y=3: oREQUEST=0 that cycle; two cycles later oRED=0 at oX_POS=100; oUNDERFLOW goes to 1 and stays 1 until reset.
- Enable and reset:
  - Drop iEN at line 200: the frame completes through y=524, then the FSM enters IDLE. oREQUEST stays 0 and the syncs stay high.
  - Assert iRST_N=0 at x=300: on the next edge all outputs take their reset values.
- Test pattern (macro defined, iPATTERN_SEL=1): oREQUEST never asserts. At x=0, output is 3FF/3FF/3FF; at x=80, 3FF/3FF/000; at x=560, 000/000/000.
